// File: rtl/mem_scan_initiator.sv
// mem_scan_initiator
//   Bus initiator that sweeps a word range of a single-word request/ready memory.
//   FILL writes a constant to every word; VERIFY reads every word and counts the
//   words that differ from the constant.
// Ports
//   i_clock, i_reset         clock, asynchronous active-low reset
//   i_start, i_mode          start command (taken in IDLE only), 0 = FILL, 1 = VERIFY
//   i_base, i_count, i_value operation arguments, captured on start
//   o_busy, o_done           sweep in progress / one-cycle completion pulse
//   o_error, o_error_count,  VERIFY result: any mismatch, saturating mismatch count,
//   o_first_error_address    byte address of the first mismatch
//   o_request, o_rw,         bus request, direction (1 = write), byte address,
//   o_address, o_wdata       write data
//   i_rdata, i_ready         bus read data and completion from the responder
module mem_scan_initiator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_LSH   = 2,
    parameter int unsigned COUNT_BITS = 24
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [31:0]           i_base,
    input  logic [COUNT_BITS-1:0] i_count,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [COUNT_BITS-1:0] o_error_count,
    output logic [31:0]           o_first_error_address,
    output logic                  o_request,
    output logic                  o_rw,
    output logic [31:0]           o_address,
    output logic [WIDTH-1:0]      o_wdata,
    input  logic [WIDTH-1:0]      i_rdata,
    input  logic                  i_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StRelease, StDone} state_t;

    state_t                state_q, state_d;
    logic [31:0]           base_q;
    logic [COUNT_BITS-1:0] count_q;
    logic [WIDTH-1:0]      value_q;
    logic                  mode_q;
    logic [COUNT_BITS-1:0] index_q, index_d;
    logic [COUNT_BITS-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]           first_addr_q, first_addr_d;
    logic                  capture;
    logic [31:0]           cur_addr;

    // Address arithmetic wraps modulo 2^32.
    assign cur_addr = base_q + (32'(index_q) << ADDR_LSH);

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        err_cnt_d    = err_cnt_q;
        first_addr_d = first_addr_q;
        capture      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    capture      = 1'b1;
                    index_d      = '0;
                    err_cnt_d    = '0;
                    first_addr_d = '0;
                    state_d      = (i_count == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (i_ready) begin
                    if (mode_q && (i_rdata != value_q)) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        // Error count is cleared on start, so zero means no mismatch yet.
                        if (err_cnt_q == '0) first_addr_d = cur_addr;
                    end
                    index_d = index_q + 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Hold off the next request until the responder has dropped ready.
                if (!i_ready) state_d = (index_q == count_q) ? StDone : StReq;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            base_q       <= '0;
            count_q      <= '0;
            value_q      <= '0;
            mode_q       <= 1'b0;
            index_q      <= '0;
            err_cnt_q    <= '0;
            first_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            err_cnt_q    <= err_cnt_d;
            first_addr_q <= first_addr_d;
            if (capture) begin
                base_q  <= i_base;
                count_q <= i_count;
                value_q <= i_value;
                mode_q  <= i_mode;
            end
        end
    end

    // Outputs decode straight from the state register so reset clears them at once.
    assign o_request             = (state_q == StReq);
    assign o_rw                  = o_request & ~mode_q;
    assign o_address             = o_request ? cur_addr : '0;
    assign o_wdata               = (o_request && !mode_q) ? value_q : '0;
    assign o_busy                = (state_q == StReq) || (state_q == StRelease);
    assign o_done                = (state_q == StDone);
    assign o_error               = (err_cnt_q != '0);
    assign o_error_count         = err_cnt_q;
    assign o_first_error_address = first_addr_q;

endmodule

// File: tb/tb_mem_scan_initiator.sv
// Bench for mem_scan_initiator: directed vector table, a mid-sweep reset sequence and
// randomized FILL/VERIFY pairs checked against a word-level reference model.
module tb_mem_scan_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic [31:0] i_base = '0;
    logic [23:0] i_count = '0;
    logic [31:0] i_value = '0;
    logic        o_busy, o_done, o_error, o_request, o_rw;
    logic [23:0] o_error_count;
    logic [31:0] o_first_error_address, o_address, o_wdata, rdata;
    logic        ready;

    always #5 clk = ~clk;

    mem_scan_initiator dut (
        .i_clock               (clk),
        .i_reset               (rst_n),
        .i_start               (i_start),
        .i_mode                (i_mode),
        .i_base                (i_base),
        .i_count               (i_count),
        .i_value               (i_value),
        .o_busy                (o_busy),
        .o_done                (o_done),
        .o_error               (o_error),
        .o_error_count         (o_error_count),
        .o_first_error_address (o_first_error_address),
        .o_request             (o_request),
        .o_rw                  (o_rw),
        .o_address             (o_address),
        .o_wdata               (o_wdata),
        .i_rdata               (rdata),
        .i_ready               (ready)
    );

    // Responder: ready after ws wait cycles, optionally left high one extra cycle.
    logic [31:0] mem [256];
    int          ws = 0;
    bit          hold_en = 1'b0;
    int          cnt_q = 0;
    logic        hold_q = 1'b0;
    logic [31:0] garbage_q = '0;

    assign ready = (o_request && (cnt_q >= ws)) || hold_q;
    assign rdata = (o_request && ready && !o_rw) ? mem[o_address[9:2]] : garbage_q;

    always @(posedge clk) begin
        if (!o_request || ready) cnt_q <= 0;
        else cnt_q <= cnt_q + 1;
        hold_q    <= hold_en && o_request && ready;
        garbage_q <= $urandom;
    end

    // Bus monitor: logs completions and counts handshake violations.
    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
    } txn_t;
    txn_t txq[$];
    int   proto_err = 0;
    logic prev_pend = 1'b0;
    logic prev_comp = 1'b0;
    txn_t prev_t = '0;

    always @(negedge clk) begin
        if (o_request && ready) txq.push_back('{o_address, o_rw, o_wdata});
        if (prev_pend && !(o_request && o_address == prev_t.addr && o_rw == prev_t.rw
                           && o_wdata == prev_t.wdata))
            proto_err <= proto_err + 1;
        if (prev_comp && o_request && ready) proto_err <= proto_err + 1;
        prev_pend <= o_request && !ready;
        prev_comp <= o_request && ready;
        prev_t    <= '{o_address, o_rw, o_wdata};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          mode;
        logic [31:0] base;
        int          count;
        logic [31:0] value;
        int          ws;
        bit          hold;
        bit          poke;
        bit          pre;
        logic [31:0] pre_val;
        int          cor_idx;
        logic [31:0] cor_val;
        int          exp_cnt;
        logic [31:0] exp_first;
    } vec_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input int i);
        return base + (32'(i) << 2);
    endfunction

    // Word-level model of VERIFY: count words that differ from value, note the first.
    task automatic model_verify(input logic [31:0] base, input int count,
                                input logic [31:0] value, output int cnt,
                                output logic [31:0] first);
        logic [31:0] a;
        cnt   = 0;
        first = '0;
        for (int i = 0; i < count; i++) begin
            a = word_addr(base, i);
            if (mem[a[9:2]] != value) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        end
    endtask

    task automatic run_op(input vec_t v, input int exp_cnt, input logic [31:0] exp_first,
                          input string tag);
        int   tb, pb, cycles, exp_cycles, busy_bad, bad;
        bit   got;
        txn_t e;
        string first_bad;
        tb = txq.size();
        pb = proto_err;
        ws = v.ws;
        hold_en = v.hold;
        exp_cycles = v.count * (2 + v.ws + int'(v.hold)) + 2;
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = v.mode;
        i_base  = v.base;
        i_count = 24'(v.count);
        i_value = v.value;
        cycles = 1;
        busy_bad = 0;
        got = 1'b0;
        while (cycles < 5000) begin
            @(negedge clk);
            cycles++;
            i_start = v.poke && (cycles == 3);
            if (i_start) begin
                i_base  = 32'h5555_0000;
                i_count = 24'd1;
                i_mode  = ~v.mode;
                i_value = ~v.value;
            end
            if (o_done) begin
                got = 1'b1;
                break;
            end
            if (!o_busy) busy_bad++;
        end
        i_start = 1'b0;
        chk({tag, ".done_seen"}, longint'(got), 1);
        chk({tag, ".cycles"}, cycles, exp_cycles);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".n_txn"}, txq.size() - tb, v.count);
        bad = 0;
        first_bad = "";
        for (int i = 0; i < v.count; i++) begin
            e = '{word_addr(v.base, i), ~v.mode, v.mode ? 32'h0 : v.value};
            if (tb + i >= txq.size() || txq[tb + i] != e) begin
                if (bad == 0)
                    first_bad = $sformatf("%s.txn%0d", tag, i);
                bad++;
            end
        end
        chk((bad != 0) ? first_bad : {tag, ".txn"}, bad, 0);
        chk({tag, ".error"}, longint'(o_error), longint'(exp_cnt != 0));
        chk({tag, ".err_cnt"}, longint'(o_error_count), exp_cnt);
        chk({tag, ".first_addr"}, longint'(o_first_error_address), longint'(exp_first));
        @(negedge clk);
        chk({tag, ".done_pulse"}, longint'({o_done, o_busy}), 0);
        chk({tag, ".proto"}, proto_err - pb, 0);
        for (int i = tb; i < txq.size(); i++)
            if (txq[i].rw) mem[txq[i].addr[9:2]] = txq[i].wdata;
    endtask

    vec_t        vt[9];
    vec_t        r;
    logic [31:0] a;
    int          n, tb0, ecnt, nk, idx;
    logic [31:0] efirst;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
        //         mode base          cnt value         ws hold poke pre pre_val  cor  cor_val exp first
        vt[0] = '{1'b0, 32'h100,       4, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        vt[1] = '{1'b1, 32'h0,         8, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0, 5, 32'h1, 1, 32'h14};
        vt[2] = '{1'b0, 32'h40,        0, 32'h1234,     0, 1'b0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        vt[3] = '{1'b0, 32'h200,       3, 32'hA5A5A5A5, 5, 1'b0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        vt[4] = '{1'b1, 32'h200,       3, 32'hA5A5A5A5, 5, 1'b1, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        vt[5] = '{1'b0, 32'hFFFFFFF8,  4, 32'h12345678, 0, 1'b1, 1'b1, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        vt[6] = '{1'b1, 32'hFFFFFFF8,  4, 32'h12345678, 1, 1'b0, 1'b1, 1'b0, 32'h0, 2, 32'h0, 1, 32'h0};
        vt[7] = '{1'b1, 32'h1000,      5, 32'h0F0F0F0F, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, -1, 32'h0,
                  5, 32'h1000};
        vt[8] = '{1'b0, 32'h1000,      5, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.request", longint'(o_request), 0);
        chk("reset.busy_done", longint'({o_busy, o_done}), 0);
        chk("reset.address", longint'(o_address), 0);
        chk("reset.errors", longint'({o_error, o_error_count, o_first_error_address}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors
        for (int t = 0; t < 9; t++) begin
            if (vt[t].pre)
                for (int i = 0; i < vt[t].count; i++) begin
                    a = word_addr(vt[t].base, i);
                    mem[a[9:2]] = vt[t].pre_val;
                end
            if (vt[t].cor_idx >= 0) begin
                a = word_addr(vt[t].base, vt[t].cor_idx);
                mem[a[9:2]] = vt[t].cor_val;
            end
            run_op(vt[t], vt[t].exp_cnt, vt[t].exp_first, $sformatf("vec%0d", t));
        end

        // Reset during word 3 of an 8-word sweep with wait states
        ws = 2;
        hold_en = 1'b0;
        tb0 = txq.size();
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 1'b0;
        i_base  = 32'h300;
        i_count = 24'd8;
        i_value = 32'h77;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (!((txq.size() - tb0 >= 3) && o_request) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.reached_word3", longint'(n < 200), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.request", longint'(o_request), 0);
        chk("midrst.busy", longint'(o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r = '{1'b0, 32'h300, 8, 32'h77, 2, 1'b0, 1'b0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0};
        run_op(r, 0, 32'h0, "midrst.resweep");

        // Randomized FILL then corrupted VERIFY against the model
        for (int it = 0; it < 8; it++) begin
            r.mode  = 1'b0;
            r.base  = (it % 3 == 0) ? 32'hFFFFFFE0 : ($urandom & 32'hFFFFFFFC);
            r.count = $urandom_range(0, 12);
            r.value = $urandom;
            r.ws    = $urandom_range(0, 3);
            r.hold  = 1'($urandom_range(0, 1));
            r.poke  = 1'($urandom_range(0, 1));
            run_op(r, 0, 32'h0, $sformatf("rnd%0d.fill", it));
            if (r.count > 0) begin
                nk = $urandom_range(0, 3);
                for (int k = 0; k < nk; k++) begin
                    idx = $urandom_range(0, r.count - 1);
                    a = word_addr(r.base, idx);
                    mem[a[9:2]] = mem[a[9:2]] ^ (32'h1 << $urandom_range(0, 31));
                end
            end
            r.mode = 1'b1;
            r.ws   = $urandom_range(0, 3);
            model_verify(r.base, r.count, r.value, ecnt, efirst);
            run_op(r, ecnt, efirst, $sformatf("rnd%0d.verify", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
